// File: rtl/noc_local_injector.sv
// Local injection port for a mesh node: buffers core requests in a small FIFO
// and emits them as flits when the router's local input port can take them.
module noc_local_injector #(
  parameter int NODE_ID     = 0,
  parameter int FIFO_DEPTH  = 4,
  parameter int STALL_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_dest,
  input  logic [7:0]  req_payload,
  input  logic        local_full,
  output logic [16:0] data_o,
  output logic [15:0] inj_count,
  output logic [7:0]  self_drop_count,
  output logic        stall_err
);

  // state   | meaning
  // IDLE    | FIFO empty, nothing to send
  // SEND    | popping one flit per edge while local_full is low
  // BLOCKED | router full; holding the head and counting stall cycles
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SEND    = 2'd1;
  localparam logic [1:0] BLOCKED = 2'd2;

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT + 1) : 1;
  localparam logic [3:0]    SRC   = 4'(NODE_ID);
  localparam logic [CW-1:0] LIMIT = CW'(STALL_LIMIT);

  logic [11:0]   mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [1:0]    state, state_nxt;
  logic [CW-1:0] stall_cnt;
  logic          ready_en;
  logic          empty, full, accept, self_hit, push, pop;
  logic [11:0]   head;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // ready_en holds req_ready low until the first edge after reset release
  assign req_ready = ready_en & ~full;
  assign accept    = req_valid & req_ready;
  assign self_hit  = (req_dest == SRC);
  assign push      = accept & ~self_hit;
  assign pop       = (state == SEND) & ~empty & ~local_full;
  assign head      = mem[rd_ptr[AW-1:0]];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = local_full ? BLOCKED : SEND;
      SEND: begin
        if (empty)           state_nxt = IDLE;
        else if (local_full) state_nxt = BLOCKED;
      end
      BLOCKED: if (!local_full) state_nxt = empty ? IDLE : SEND;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {req_dest, req_payload};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      ready_en        <= 1'b0;
      data_o          <= '0;
      inj_count       <= '0;
      self_drop_count <= '0;
      stall_cnt       <= '0;
      stall_err       <= 1'b0;
    end else begin
      state    <= state_nxt;
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + (AW+1)'(1);
        data_o    <= {1'b1, head[11:8], SRC, head[7:0]};
        inj_count <= inj_count + 16'd1;
      end else begin
        data_o <= '0;
      end
      if (accept && self_hit && self_drop_count != 8'hFF)
        self_drop_count <= self_drop_count + 8'd1;
      if (state == BLOCKED && state_nxt == BLOCKED) begin
        if (stall_cnt != LIMIT) stall_cnt <= stall_cnt + CW'(1);
      end else begin
        stall_cnt <= '0;
      end
      if (stall_cnt == LIMIT) stall_err <= 1'b1;
    end
  end

endmodule

// File: doc/noc_local_injector.md
NOC_LOCAL_INJECTOR -- requirements
Module: noc_local_injector

Interface
REQ-001 Parameter NODE_ID, default 0, meaning: this node's 4-bit mesh address (0..15), inserted as source field.
REQ-002 Parameter FIFO_DEPTH, default 4, meaning: request buffer entries, power of two, 2..16.
REQ-003 Parameter STALL_LIMIT, default 255, meaning: consecutive blocked cycles before stall error.
REQ-004 clk  input  1  meaning: single clock; all state changes on its rising edge.
REQ-005 rst  input  1  meaning: reset, asynchronous, active-low.
REQ-006 req_valid  input  1  meaning: core offers a packet request.
REQ-007 req_ready  output  1  meaning: request buffer can accept this cycle.
REQ-008 req_dest  input  4  meaning: destination node address.
REQ-009 req_payload  input  8  meaning: packet payload.
REQ-010 local_full  input  1  meaning: network local input port cannot accept a flit.
REQ-011 data_o  output  17  meaning: flit to the network node's data_i port.
REQ-012 inj_count  output  16  meaning: number of flits injected.
REQ-013 self_drop_count  output  8  meaning: number of self-addressed requests discarded.
REQ-014 stall_err  output  1  meaning: sticky flag, injection blocked too long.

Function
REQ-015 The flit format SHALL be data_o[16] = valid, [15:12] = dest, [11:8] = NODE_ID, [7:0] = payload; an idle flit SHALL be all zeros.
REQ-016 A request SHALL be accepted on a rising edge when req_valid and req_ready are both 1; req_ready SHALL be 1 exactly when the FIFO is not full.
REQ-017 An accepted request with req_dest == NODE_ID SHALL NOT enter the FIFO; it SHALL increment self_drop_count, which saturates at 255.
REQ-018 The FIFO SHALL be first-in first-out, using wrap-around read and write pointers with one extra bit for full/empty discrimination.
REQ-019 A simultaneous push and pop on a full FIFO SHALL be illegal, because req_ready is 0 when full; a simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the occupancy unchanged.
REQ-020 The FSM SHALL have the states IDLE, SEND and BLOCKED.
REQ-021 IDLE -> SEND SHALL occur when the FIFO is non-empty and local_full is 0; IDLE -> BLOCKED SHALL occur when the FIFO is non-empty and local_full is 1.
REQ-022 In SEND, on every edge with the FIFO non-empty and local_full at 0, the head SHALL be popped and registered onto data_o with valid set, one cycle after the pop decision.
REQ-023 In SEND, when the FIFO is empty, the FSM SHALL go to IDLE; when local_full is 1, it SHALL go to BLOCKED.
REQ-024 In BLOCKED, data_o SHALL be zero, no pop SHALL occur, and a stall counter SHALL increment each cycle.
REQ-025 BLOCKED -> SEND SHALL occur when local_full falls and the FIFO is non-empty; the stall counter SHALL clear on exit.
REQ-026 When the stall counter reaches STALL_LIMIT, stall_err SHALL be set and SHALL stay set until reset.
REQ-027 In any cycle without a pop, data_o SHALL be zero, so no flit is ever emitted twice.
REQ-028 Peak throughput SHALL be one flit per cycle; latency from request acceptance into an empty FIFO to the valid flit on data_o SHALL be 2 cycles when local_full is 0.
REQ-029 inj_count SHALL increment once per valid flit emitted and SHALL wrap from 65535 to 0.
REQ-030 local_full SHALL be sampled only at the rising edge on which the pop is decided.

Reset
REQ-031 On rst low, immediately and regardless of clk, the FSM SHALL go to IDLE, the FIFO pointers SHALL clear to empty, and the outputs SHALL take these values: data_o = 0, req_ready = 0, inj_count = 0, self_drop_count = 0, stall_err = 0, stall counter = 0.
REQ-032 req_ready SHALL rise on the first clk edge after rst is released.
REQ-033 Reset during BLOCKED or SEND SHALL discard all buffered requests, and no partial flit SHALL be emitted.

Verification
REQ-034 NODE_ID=5, push dest=3 payload=0xA7 with local_full=0 -> data_o=17'h1_35A7 two cycles after acceptance, inj_count=1.
REQ-035 Push 5 requests back-to-back with local_full=1 -> req_ready=0 after 4 accepts; release local_full -> 4 flits emitted on consecutive cycles in order, FIFO empty, FSM IDLE.
REQ-036 NODE_ID=5, push dest=5 -> no flit emitted, self_drop_count=1, req_ready remains 1.
REQ-037 One request pending, local_full held at 1 for 256 cycles with STALL_LIMIT=255 -> stall_err=1 and held; release -> flit emitted, stall_err still 1.
REQ-038 Toggle local_full every cycle during a 4-flit burst -> each flit emitted exactly once, order preserved, zero flits in blocked cycles.
REQ-039 Assert rst mid-burst with 3 entries buffered -> data_o=0 asynchronously, all counters 0; after release no stale flit appears.
